sobel_edge: RTL and testbench

SOBEL_EDGE -- requirements
Module: sobel_edge

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sobel_line_buf.sv | 22 ++
 rtl/sobel_edge.sv | 134 +++++++++++++
 tb/tb_sobel_edge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and small arithmetic helpers for the binary Sobel edge detector.
package sobel_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int GRAD_W    = 4;
  localparam int MAG_W     = 4;

  // Weighted 1-2-1 sum of three binary taps, range 0..4.
  function automatic logic [2:0] wsum(input logic a, input logic b, input logic c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic signed [GRAD_W-1:0] grad(input logic [2:0] pos, input logic [2:0] neg);
    return $signed({1'b0, pos}) - $signed({1'b0, neg});
  endfunction

  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line history buffer: one 2-bit word per column, combinational read, write on clock.
// A write lands at the clock edge, so the same-cycle read still sees the old word.
module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    wdata,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector on a binary raster; 2-cycle latency, or 3 cycles
// when SOBEL_OUT_REG_EN is defined (extra register on all four outputs).
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int THRESH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_vld,
  input  logic din_sop,
  input  logic din_eop,
  output logic dout,
  output logic dout_vld,
  output logic dout_sop,
  output logic dout_eop
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic          unused_eop;
  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic [1:0]    lb_rd;
  logic [2:0]    new_col, win_c0, win_c1, win_c2;
  logic          s1_vld, s1_sop, s1_eop;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [MAG_W-1:0] mag;
  logic          edge_q, vld_q, sop_q, eop_q;

  assign unused_eop = din_eop;

  // A qualified sop places the current pixel at (0,0) regardless of the counters.
  always_comb begin
    cur_col = din_sop ? '0 : col_cnt;
    cur_row = din_sop ? '0 : row_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (din_vld) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_cnt <= cur_col + 1'b1;
        row_cnt <= cur_row;
      end
    end
  end

  // Word layout: [1] = two rows up, [0] = one row up.
  sobel_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_buf (
    .clk   (clk),
    .we    (din_vld),
    .addr  (cur_col),
    .wdata ({lb_rd[0], din}),
    .rdata (lb_rd)
  );

  // Column vector bits: [0] top row, [1] middle row, [2] bottom row (current pixel).
  assign new_col = {din, lb_rd[0], lb_rd[1]};

  always_ff @(posedge clk) begin
    if (din_vld) begin
      win_c0 <= win_c1;
      win_c1 <= win_c2;
      win_c2 <= new_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
    end else begin
      s1_vld <= din_vld && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      s1_sop <= din_vld && (cur_row == RW'(2)) && (cur_col == CW'(2));
      s1_eop <= din_vld && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    end
  end

  always_comb begin
    gx  = grad(wsum(win_c2[0], win_c2[1], win_c2[2]), wsum(win_c0[0], win_c0[1], win_c0[2]));
    gy  = grad(wsum(win_c0[2], win_c1[2], win_c2[2]), wsum(win_c0[0], win_c1[0], win_c2[0]));
    mag = abs_grad(gx) + abs_grad(gy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= 1'b0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      edge_q <= s1_vld && (mag >= MAG_W'(THRESH));
      vld_q  <= s1_vld;
      sop_q  <= s1_vld && s1_sop;
      eop_q  <= s1_vld && s1_eop;
    end
  end

`ifdef SOBEL_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout     <= edge_q;
      dout_vld <= vld_q;
      dout_sop <= sop_q;
      dout_eop <= eop_q;
    end
  end
`else
  assign dout     = edge_q;
  assign dout_vld = vld_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;
`endif

endmodule

// File: tb/tb_sobel_edge.sv
// Randomized bench for sobel_edge on a small frame; image-array reference model with a
// cycle-exact expectation queue.
module tb_sobel_edge;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int TH = 2;
  localparam int NRES = (W - 2) * (H - 2);
`ifdef SOBEL_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0, din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic dout, dout_vld, dout_sop, dout_eop;

  sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int due;
    bit d;
    bit s;
    bit e;
  } exp_t;

  exp_t q[$];
  bit   img[H][W];
  int   mr = 0, mc = 0;
  int   tests_run = 0, n_fail = 0;
  int   n_vld = 0, n_sop = 0, n_eop = 0, n_ones = 0;
  bit   mon_en = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    tests_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_edge(int r, int c);
    int p[3][3];
    int gx, gy, ax, ay;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j] ? 1 : 0;
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    return (ax + ay) >= TH;
  endfunction

  // Scoreboard: every cycle, dout_vld must be high exactly when a result is due.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   ev;
      exp_t e;
      ev = (q.size() > 0) && (q[0].due == cyc);
      check("dout_vld", dout_vld, ev ? 1 : 0);
      if (ev) begin
        e = q.pop_front();
        check("dout", dout, e.d ? 1 : 0);
        check("dout_sop", dout_sop, e.s ? 1 : 0);
        check("dout_eop", dout_eop, e.e ? 1 : 0);
      end else begin
        check("idle_flags", {dout, dout_sop, dout_eop}, 0);
      end
      if (dout_vld === 1'b1) begin
        n_vld++;
        if (dout === 1'b1) n_ones++;
        if (dout_sop === 1'b1) n_sop++;
        if (dout_eop === 1'b1) n_eop++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      din_vld = 1'b0;
      din     = 1'($urandom);
      din_sop = 1'($urandom);
      din_eop = 1'($urandom);
    end
  endtask

  task automatic send(input bit pix, input bit sop, input int gap);
    exp_t e;
    idle(gap);
    @(posedge clk); #1;
    din_vld = 1'b1;
    din     = pix;
    din_sop = sop;
    din_eop = ($urandom_range(0, 15) == 0);
    if (sop) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      e.due = cyc + LAT;
      e.d   = model_edge(mr, mc);
      e.s   = (mr == 2 && mc == 2);
      e.e   = (mr == H - 1 && mc == W - 1);
      q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
  endtask

  // mode: 0 zeros, 1 ones, 2 vertical edge at W/2, 3 random
  function automatic bit pix_of(int mode, int c);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return c >= W / 2;
      default: return 1'($urandom);
    endcase
  endfunction

  task automatic send_pixels(input int mode, input int npix, input int gmin, input int gmax);
    for (int k = 0; k < npix; k++)
      send(pix_of(mode, k % W), k == 0, $urandom_range(gmax, gmin));
  endtask

  task automatic clear_counts();
    n_vld = 0; n_sop = 0; n_eop = 0; n_ones = 0;
  endtask

  task automatic check_counts(input string tag, input int vld, input int sop, input int eop);
    idle(LAT + 4);
    check({tag, "_nres"}, n_vld, vld);
    check({tag, "_nsop"}, n_sop, sop);
    check({tag, "_neop"}, n_eop, eop);
    check({tag, "_drain"}, q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst     = 1'b1;
    din_vld = 1'b0;
    while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    mr  = 0;
    mc  = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_vld", dout_vld, 0);
    check("rst_sop", dout_sop, 0);
    check("rst_eop", dout_eop, 0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    clear_counts();
    send_pixels(0, W * H, 1, 1);
    check_counts("zeros", NRES, 1, 1);
    check("zeros_ones", n_ones, 0);

    clear_counts();
    send_pixels(1, W * H, 0, 0);
    check_counts("ones", NRES, 1, 1);
    check("ones_ones", n_ones, 0);

    clear_counts();
    send_pixels(2, W * H, 0, 2);
    check_counts("vedge", NRES, 1, 1);
    check("vedge_ones", n_ones, 2 * (H - 2));

    for (int f = 0; f < 4; f++) begin
      clear_counts();
      send_pixels(3, W * H, 0, (f == 0) ? 0 : 3);
      check_counts("rand", NRES, 1, 1);
    end

    send_pixels(3, 90, 0, 1);
    do_reset();
    clear_counts();
    send_pixels(3, W * H, 0, 2);
    check_counts("post_rst", NRES, 1, 1);

    // Partial frame of 100 pixels (rows 0..5 plus 4 pixels of row 6), then a restart.
    clear_counts();
    send_pixels(3, 100, 0, 1);
    send_pixels(3, W * H, 0, 1);
    check_counts("resop", 4 * (W - 2) + 2 + NRES, 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
